// File: rtl/afc_cal_sequencer_if.sv
// ---------------------------------------------------------------------------
// afc_cal_sequencer_if
// Bundles the control side (start/target/tol/result) and the FSM side
// (state_out, fsm_rst_n, comp_code) of the AFC calibration sequencer.
//   start       single-cycle run request
//   vco_tick    one-cycle pulse per divided-VCO edge (clk domain)
//   target_cnt  expected ticks per window
//   tol         allowed +/- deviation
//   state_out   afc_fsm_6bit state, bit 5 = finished
//   fsm_rst_n   active-low reset to afc_fsm_6bit
//   comp_code   100 fast, 010 slow, 001 freeze, 000 hold
//   busy/done/fail/last_cnt  run status
// slave = sequencer side, master = driver/front-end side.
// ---------------------------------------------------------------------------
interface afc_cal_sequencer_if #(parameter int CW = 16);
   logic          start;
   logic          vco_tick;
   logic [CW-1:0] target_cnt;
   logic [CW-1:0] tol;
   logic [5:0]    state_out;
   logic          fsm_rst_n;
   logic [2:0]    comp_code;
   logic          busy;
   logic          done;
   logic          fail;
   logic [CW-1:0] last_cnt;

   modport slave (
      input  start, vco_tick, target_cnt, tol, state_out,
      output fsm_rst_n, comp_code, busy, done, fail, last_cnt
   );

   modport master (
      output start, vco_tick, target_cnt, tol, state_out,
      input  fsm_rst_n, comp_code, busy, done, fail, last_cnt
   );
endinterface

// File: rtl/afc_cal_sequencer.sv
// ---------------------------------------------------------------------------
// afc_cal_sequencer
// Runs one automatic frequency calibration around afc_fsm_6bit: reset the
// FSM, settle, count VCO ticks over a fixed window, compare to
// target +/- tol, issue a one-cycle slow/fast/freeze code, repeat until the
// FSM reports finished or the step budget runs out.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  afc_cal_sequencer_if.slave (control + FSM handshake)
// ---------------------------------------------------------------------------
module afc_cal_sequencer #(
   parameter int CW        = 16,
   parameter int WINDOW    = 256,
   parameter int SETTLE    = 32,
   parameter int MAX_STEPS = 8
) (
   input logic               clk,
   input logic               rst,
   afc_cal_sequencer_if.slave bus
);
   localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int SW   = $clog2(MAX_STEPS + 1);
   localparam logic [CW-1:0] CMAX = '1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FSM_RST = 3'd1;
   localparam logic [2:0] S_SETTLE  = 3'd2;
   localparam logic [2:0] S_MEASURE = 3'd3;
   localparam logic [2:0] S_DECIDE  = 3'd4;
   localparam logic [2:0] S_ISSUE   = 3'd5;
   localparam logic [2:0] S_CHECK   = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   localparam logic [2:0] C_HOLD = 3'b000;
   localparam logic [2:0] C_FAST = 3'b100;
   localparam logic [2:0] C_SLOW = 3'b010;
   localparam logic [2:0] C_FRZ  = 3'b001;

   logic [2:0]    state;
   logic [TW-1:0] tmr;
   logic [CW-1:0] cnt, tgt_q, tol_q, last_q;
   logic [SW-1:0] steps;
   logic [2:0]    code_q;
   logic          fail_q;

   // Saturating acceptance band.
   logic [CW:0]   sum;
   logic [CW-1:0] lo, hi;
   logic [2:0]    code_dec;
   logic          forced;

   assign sum = {1'b0, tgt_q} + {1'b0, tol_q};
   assign lo  = (tol_q > tgt_q) ? '0 : tgt_q - tol_q;
   assign hi  = sum[CW] ? CMAX : sum[CW-1:0];

   always_comb begin
      code_dec = C_FRZ;
      forced   = 1'b0;
      if (cnt < lo)      code_dec = C_SLOW;
      else if (cnt > hi) code_dec = C_FAST;
      // Step budget spent: stop moving the band and flag the run as failed.
      if (code_dec != C_FRZ && steps == SW'(MAX_STEPS)) begin
         code_dec = C_FRZ;
         forced   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         tmr    <= '0;
         cnt    <= '0;
         tgt_q  <= '0;
         tol_q  <= '0;
         last_q <= '0;
         steps  <= '0;
         code_q <= C_HOLD;
         fail_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (bus.start) begin
               tgt_q  <= bus.target_cnt;
               tol_q  <= bus.tol;
               fail_q <= 1'b0;
               steps  <= '0;
               tmr    <= TW'(1);
               state  <= S_FSM_RST;
            end
            S_FSM_RST: if (tmr == '0) begin
               tmr   <= TW'(SETTLE - 1);
               cnt   <= '0;
               state <= S_SETTLE;
            end else tmr <= tmr - 1'b1;
            S_SETTLE: if (tmr == '0) begin
               tmr   <= TW'(WINDOW - 1);
               state <= S_MEASURE;
            end else tmr <= tmr - 1'b1;
            S_MEASURE: begin
               if (bus.vco_tick && cnt != CMAX) cnt <= cnt + 1'b1;
               if (tmr == '0) state <= S_DECIDE;
               else           tmr   <= tmr - 1'b1;
            end
            S_DECIDE: begin
               last_q <= cnt;
               code_q <= code_dec;
               if (forced) fail_q <= 1'b1;
               state  <= S_ISSUE;
            end
            S_ISSUE: begin
               if (code_q != C_FRZ) steps <= steps + 1'b1;
               state <= S_CHECK;
            end
            // FSM has taken the code on the ISSUE edge; bit 5 is now valid.
            S_CHECK: begin
               if (code_q == C_FRZ) begin
                  if (!bus.state_out[5]) fail_q <= 1'b1;
                  state <= S_DONE;
               end else if (bus.state_out[5]) begin
                  fail_q <= 1'b1;          // band range exhausted
                  state  <= S_DONE;
               end else begin
                  tmr   <= TW'(SETTLE - 1);
                  cnt   <= '0;
                  state <= S_SETTLE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Band index bits are not needed by the sequencer.
   logic unused_state;
   assign unused_state = ^bus.state_out[4:0];

   // fsm_rst_n follows rst directly so an abort resets the FSM at once.
   assign bus.fsm_rst_n = ~rst & (state != S_FSM_RST);
   assign bus.comp_code = (state == S_ISSUE) ? code_q : C_HOLD;
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.fail      = fail_q;
   assign bus.last_cnt  = last_q;
endmodule

// File: tb/tb_afc_cal_sequencer.sv
// ---------------------------------------------------------------------------
// tb_afc_cal_sequencer
// Directed bench for afc_cal_sequencer (CW=8, WINDOW=16, SETTLE=4,
// MAX_STEPS=3). A small afc_fsm_6bit stand-in closes the loop. A timeline
// model predicts every output each cycle; per-run literal checks pin it.
// ---------------------------------------------------------------------------
module tb_afc_cal_sequencer;
   localparam int CW = 8;
   localparam int PER = 23;               // SETTLE + WINDOW + 3
   localparam int CSAT = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   afc_cal_sequencer_if #(.CW(CW)) bus();

   afc_cal_sequencer #(.CW(CW), .WINDOW(16), .SETTLE(4), .MAX_STEPS(3)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // afc_fsm_6bit stand-in: band steps on slow/fast, finished on freeze or
   // when the band runs off either end.
   logic [4:0] band = 5'd16;
   logic       fin = 1'b0;
   logic       force0 = 1'b0;
   always_ff @(posedge clk or negedge bus.fsm_rst_n)
      if (!bus.fsm_rst_n) begin
         band <= 5'd16;
         fin  <= 1'b0;
      end else begin
         case (bus.comp_code)
            3'b100:  if (band == 5'd0)  fin <= 1'b1; else band <= band - 1'b1;
            3'b010:  if (band == 5'd31) fin <= 1'b1; else band <= band + 1'b1;
            3'b001:  fin <= 1'b1;
            default: ;
         endcase
      end
   assign bus.state_out = {fin & ~force0, band};

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---- timeline model: cycle p of a run (p=0 start cycle) ----
   bit         m_run = 0;
   int         m_p = 0, m_done_p = -1, m_cnt = 0, m_steps = 0, m_tgt = 0, m_tol = 0;
   int         m_last = 0;
   bit         m_fail = 0;
   logic [2:0] m_code = 3'b000;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_run = 0; m_fail = 0; m_last = 0; m_done_p = -1;
      end else if (!m_run) begin
         if (bus.start) begin
            m_run = 1; m_p = 1; m_done_p = -1; m_cnt = 0; m_steps = 0; m_fail = 0;
            m_tgt = int'(bus.target_cnt); m_tol = int'(bus.tol);
         end
      end else if (m_p == m_done_p) begin
         m_run = 0;
      end else begin
         if (m_p >= 3 && m_done_p < 0) begin
            int r, lo, hi;
            r = (m_p - 3) % PER;
            if (r == 0) m_cnt = 0;
            if (r >= 4 && r <= 19 && bus.vco_tick && m_cnt < CSAT) m_cnt++;
            if (r == 20) begin
               m_last = m_cnt;
               lo = (m_tgt > m_tol) ? m_tgt - m_tol : 0;
               hi = (m_tgt + m_tol > CSAT) ? CSAT : m_tgt + m_tol;
               m_code = (m_cnt < lo) ? 3'b010 : (m_cnt > hi) ? 3'b100 : 3'b001;
               if (m_code != 3'b001 && m_steps == 3) begin
                  m_code = 3'b001; m_fail = 1;
               end
            end
            if (r == 21 && m_code != 3'b001) m_steps++;
            if (r == 22) begin
               if (m_code == 3'b001 || bus.state_out[5]) begin
                  if (m_code != 3'b001 || !bus.state_out[5]) m_fail = 1;
                  m_done_p = m_p + 1;
               end
            end
         end
         m_p++;
      end
   end

   // ---- per-cycle compare + event log ----
   int codes_q[$], ccyc_q[$];
   int done_cnt = 0;
   initial forever begin
      int r;
      logic [2:0] e_code;
      bit e_busy, e_done, e_rn;
      @(negedge clk);
      r      = (m_p >= 3) ? (m_p - 3) % PER : -1;
      e_code = (m_run && m_done_p < 0 && r == 21) ? m_code : 3'b000;
      e_busy = m_run;
      e_done = m_run && (m_p == m_done_p);
      e_rn   = !rst && !(m_run && (m_p == 1 || m_p == 2));
      tests++;
      if (bus.comp_code !== e_code || bus.busy !== e_busy || bus.done !== e_done ||
          bus.fail !== m_fail || int'(bus.last_cnt) != m_last || bus.fsm_rst_n !== e_rn) begin
         fails++;
         $display("FAIL cycle %0d (got/expected): code %b/%b busy %b/%b done %b/%b fail %b/%b last %0d/%0d rst_n %b/%b",
                  cyc, bus.comp_code, e_code, bus.busy, e_busy, bus.done, e_done,
                  bus.fail, m_fail, bus.last_cnt, m_last, bus.fsm_rst_n, e_rn);
      end
      if (bus.comp_code != 3'b000) begin
         codes_q.push_back(int'(bus.comp_code));
         ccyc_q.push_back(cyc);
      end
      if (bus.done) done_cnt++;
   end

   // ---- stimulus ----
   int plan[3];
   bit all_ticks = 0;
   int code_base, done_base, start_cyc;

   function automatic logic tick_at(input int p);
      int r, k;
      if (all_ticks) return 1'b1;
      if (p < 3) return 1'b0;
      r = (p - 3) % PER;
      k = (p - 3) / PER;
      if (k > 2) k = 2;
      return (r >= 4 && r <= 19 && (r - 4) < plan[k]);
   endfunction

   task automatic run(input int tgt, input int tl, input int mid_p, input int abort_p);
      int p;
      bit ok;
      code_base = codes_q.size();
      done_base = done_cnt;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.target_cnt = CW'(tgt); bus.tol = CW'(tl);
      start_cyc = cyc; p = 0; ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         p++;
         bus.start = (p == mid_p);
         if (p == mid_p) begin bus.target_cnt = '0; bus.tol = '0; end
         bus.vco_tick = tick_at(p);
         if (p == abort_p) begin rst = 1'b1; ok = 1; break; end
         if (done_cnt != done_base) begin ok = 1; break; end
      end
      bus.start = 1'b0; bus.vco_tick = 1'b0;
      chk("run_terminates", ok, 1);
   endtask

   task automatic expect_run(input string nm, input int n, input logic [11:0] codes,
                             input int e_fail, input int e_last, input int e_dt);
      chk({nm, "_ncodes"}, codes_q.size() - code_base, n);
      for (int i = 0; i < n && code_base + i < codes_q.size(); i++)
         chk({nm, "_code"}, codes_q[code_base + i], int'(codes[3*i +: 3]));
      chk({nm, "_done_pulses"}, done_cnt - done_base, 1);
      chk({nm, "_fail"}, int'(bus.fail), e_fail);
      chk({nm, "_last_cnt"}, int'(bus.last_cnt), e_last);
      if (e_dt > 0 && codes_q.size() > code_base)
         chk({nm, "_first_code_cycle"}, ccyc_q[code_base] - start_cyc + 1, e_dt);
   endtask

   initial begin
      bus.start = 1'b0; bus.vco_tick = 1'b0; bus.target_cnt = 8'd8; bus.tol = 8'd1;
      // 1: reset hold/release
      repeat (3) @(negedge clk);
      chk("rst_fsm_rst_n", int'(bus.fsm_rst_n), 0);
      chk("rst_busy", int'(bus.busy), 0);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rel_fsm_rst_n", int'(bus.fsm_rst_n), 1);
      chk("rel_code", int'(bus.comp_code), 0);

      // 2: slow, slow, freeze (start cycle counted as cycle 1 of 25)
      plan = '{5, 5, 8}; all_ticks = 0;
      run(8, 1, 0, 0);
      expect_run("s2", 3, {3'b000, 3'b001, 3'b010, 3'b010}, 0, 8, 25);
      chk("s2_fsm_finished", int'(bus.state_out[5]), 1);

      // 3: tick every cycle -> 16 > 9: three fast then forced freeze
      all_ticks = 1;
      run(8, 1, 0, 0);
      expect_run("s3", 4, {3'b001, 3'b100, 3'b100, 3'b100}, 1, 16, 25);
      all_ticks = 0;

      // 4: band edges
      plan = '{7, 7, 7};    run(8, 1, 0, 0);  expect_run("s4_c7", 1, 12'b001, 0, 7, 25);
      plan = '{9, 9, 9};    run(8, 1, 0, 0);  expect_run("s4_c9", 1, 12'b001, 0, 9, 25);
      plan = '{10, 10, 10}; run(8, 1, 0, 0);  expect_run("s4_c10", 4, {3'b001, 3'b100, 3'b100, 3'b100}, 1, 10, 0);
      plan = '{0, 0, 0};    run(8, 10, 0, 0); expect_run("s4_lo_sat", 1, 12'b001, 0, 0, 25);
      plan = '{6, 6, 6};    run(8, 1, 0, 0);  expect_run("s4_c6", 4, {3'b001, 3'b010, 3'b010, 3'b010}, 1, 6, 0);

      // 5: reset during MEASURE, then a clean run
      plan = '{8, 8, 8};
      run(8, 1, 0, 12);
      #1;
      chk("abort_fsm_rst_n", int'(bus.fsm_rst_n), 0);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_code", int'(bus.comp_code), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_fail", int'(bus.fail), 0);
      chk("abort_last_cnt", int'(bus.last_cnt), 0);
      @(negedge clk); #1 rst = 1'b0;
      run(8, 1, 0, 0);
      expect_run("s5_rerun", 1, 12'b001, 0, 8, 25);

      // 6: start while busy ignored; finished flag held low -> fail
      force0 = 1'b1;
      run(8, 1, 10, 0);
      expect_run("s6", 1, 12'b001, 1, 8, 25);
      force0 = 1'b0;

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/afc_cal_sequencer.md
Name: afc_cal_sequencer

Overview:
- Sequences a complete automatic frequency calibration run around `afc_fsm_6bit`.
- On `start`, it resets the FSM, waits for the VCO to settle, and counts divided-VCO ticks over a fixed window.
- It compares the count against a target ± tolerance and issues one-cycle slow/fast/freeze codes into the FSM's `comp_in`.
- It repeats until the FSM reports finished (`state_out[5]`) or the step budget is exhausted. It sits between the frequency-measurement front end and `afc_fsm_6bit`.

Parameters:
- CW, 16, width of tick counter, `target_cnt` and `tol`.
- WINDOW, 256, measurement window length in clk cycles (≥ 2).
- SETTLE, 32, settling wait in clk cycles after FSM reset and after every band step (≥ 1).
- MAX_STEPS, 8, max slow/fast codes issued before forced freeze and fail.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; honoured only in IDLE
- vco_tick  in  1  one-cycle pulse per divided-VCO edge, already synchronous to clk
- target_cnt  in  CW  expected tick count per window; sampled on accepted start
- tol  in  CW  allowed ± deviation; sampled on accepted start
- state_out  in  6  from `afc_fsm_6bit`; bit 5 = finished flag
- fsm_rst_n  out  1  active-low reset to `afc_fsm_6bit`
- comp_code  out  3  to FSM `comp_in`: 100 fast, 010 slow, 001 freeze, 000 hold
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at run end
- fail  out  1  sticky result flag; cleared on next accepted start
- last_cnt  out  CW  tick count from most recent window

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - fsm_rst_n=0, comp_code=000, busy=0, done=0, fail=0, last_cnt=0.
  - Step counter and tick counter are cleared.
  - Reset mid-run aborts immediately; no code is emitted.
- IDLE:
  - fsm_rst_n=1 after reset release.
  - start=1 latches target_cnt and tol, clears fail and the step counter, then goes to FSM_RST.
  - start while busy is ignored.
- FSM_RST: fsm_rst_n=0 for exactly 2 cycles, then SETTLE.
- SETTLE: waits SETTLE cycles, then MEASURE; the tick counter is cleared on entry.
- MEASURE:
  - Lasts exactly WINDOW cycles.
  - Every cycle with vco_tick=1 increments the counter, saturating at 2^CW−1.
  - The last window cycle's tick is counted.
  - Next state is DECIDE.
- DECIDE (1 cycle):
  - last_cnt ← count.
  - lo = target−tol, saturating at 0. hi = target+tol, saturating at 2^CW−1.
  - count < lo → code slow. count > hi → code fast. Otherwise → code freeze.
  - If code is slow/fast and steps == MAX_STEPS: code is forced to freeze and fail ← 1.
- ISSUE (1 cycle):
  - comp_code = chosen code for exactly this cycle; 000 in all other states.
  - For slow/fast, steps increments.
  - Next state is CHECK.
- CHECK (1 cycle): samples state_out[5] (FSM updated on the ISSUE edge).
  - Freeze issued and bit5=1 → DONE.
  - Freeze issued and bit5=0 → fail ← 1, then DONE.
  - Slow/fast issued and bit5=1 (band range exhausted) → fail ← 1, then DONE.
  - Slow/fast issued and bit5=0 → SETTLE.
- DONE: done=1 for one cycle, then IDLE. busy falls on the same edge done falls. fail holds until the next accepted start.
- Latency of first decision after start:
  - 1 (accept) + 2 + SETTLE + WINDOW + 1 (DECIDE) + 1 (ISSUE) cycles.
  - Each further iteration adds SETTLE + WINDOW + 3.
- FSM interface: comp_code=000 means hold; the FSM never sees a code for more than one cycle.

Test Plan:
All scenarios use WINDOW=16, SETTLE=4, MAX_STEPS=3, CW=8, target_cnt=8, tol=1. The bench instantiates `afc_fsm_6bit` driven by comp_code/fsm_rst_n.

1. Reset hold then release with start=0 → fsm_rst_n=0 during reset, then 1; comp_code=000, busy=0, done=0, fail=0 throughout.
2. start; vco_tick 5 per window for 2 windows, then 8 per window:
   - comp_code sequence is 010, 010, 001, each one cycle wide.
   - last_cnt ends at 8; state_out[5]=1; done pulses; fail=0.
   - First 010 appears exactly 1+2+4+16+2 = 25 cycles after the start cycle.
3. start; vco_tick every cycle → count saturates at 16 (>9):
   - Three 100 codes are issued, then the fourth decision is forced to 001.
   - fail=1, done pulses once.
4. Boundaries with target 8, tol 1:
   - counts 7 and 9 → freeze.
   - count 6 → slow.
   - count 10 → fast.
   - tol=10, target=8 → lo saturates to 0 and count 0 gives freeze.
5. Assert rst during MEASURE → all outputs return to reset values asynchronously, before the next clk edge; a subsequent start runs cleanly from FSM_RST.
6. Pulse start again while busy → no effect: no restart and latched target unchanged. Bench force holds state_out[5]=0 after a freeze → fail=1, done pulses.
